led_sequence_player: RTL

- Sequencer that plays a stored Simon colour sequence on the 4 colour LEDs.
- Each step lights one LED for a fixed on-time, then blanks it for a fixed gap.
- Selects the active player's sequence, snapshots it at start, and reports busy and done to the game FSM.
- Sits between the game control FSM and the LED output pins. It owns o_led while playing.

---
 rtl/led_sequence_player_if.sv | 26 ++
 rtl/led_sequence_player.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/led_sequence_player_if.sv
// Control/status bundle between the game FSM (master) and the LED sequence player (slave).
interface led_sequence_player_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic                   i_start;
    logic                   i_abort;
    logic [1:0]             i_player;
    logic [2*MAX_LEN-1:0]   i_seq_p1;
    logic [2*MAX_LEN-1:0]   i_seq_p2;
    logic [LEN_W-1:0]       i_len;
    logic [3:0]             o_led;
    logic                   o_busy;
    logic                   o_done;
    logic [LEN_W-1:0]       o_step;

    modport master (
        output i_start, i_abort, i_player, i_seq_p1, i_seq_p2, i_len,
        input  o_led, o_busy, o_done, o_step
    );

    modport slave (
        input  i_start, i_abort, i_player, i_seq_p1, i_seq_p2, i_len,
        output o_led, o_busy, o_done, o_step
    );
endinterface

// File: rtl/led_sequence_player.sv
// Plays a snapshotted Simon colour sequence on four one-hot LEDs: each step is lit for
// ON_CYCLES, then blanked for OFF_CYCLES, followed by a single-cycle done pulse.
module led_sequence_player #(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 40000000,
    parameter int OFF_CYCLES = 20000000,
    parameter int LEN_W      = $clog2(MAX_LEN + 1),
    parameter int CNT_W      = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) > 2 ?
                                      ((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) : 2)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    led_sequence_player_if.slave  bus
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                      state;
    logic [MAX_LEN-1:0][1:0]     seq_snap;
    logic [LEN_W-1:0]            len_snap;
    logic [CNT_W-1:0]            timer;
    logic [3:0]                  led;
    logic                        busy;
    logic                        done;
    logic [LEN_W-1:0]            step;

    logic [MAX_LEN-1:0][1:0]     sel_seq;
    logic [LEN_W-1:0]            eff_len;
    logic [LEN_W-1:0]            step_nxt;
    logic [IDX_W-1:0]            idx_nxt;

    function automatic logic [3:0] decode(input logic [1:0] code);
        case (code)
            2'b00:   decode = 4'b0001;
            2'b01:   decode = 4'b0010;
            2'b10:   decode = 4'b0100;
            default: decode = 4'b1000;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        clamp_len = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

    assign sel_seq  = (bus.i_player == 2'b01) ? bus.i_seq_p2 : bus.i_seq_p1;
    assign eff_len  = clamp_len(bus.i_len);
    assign step_nxt = step + LEN_W'(1);
    assign idx_nxt  = step_nxt[IDX_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step     <= '0;
            timer    <= '0;
            seq_snap <= '0;
            len_snap <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    led  <= '0;
                    busy <= 1'b0;
                    // Abort outranks start even while idle.
                    if (bus.i_start && !bus.i_abort) begin
                        seq_snap <= sel_seq;
                        len_snap <= eff_len;
                        step     <= '0;
                        timer    <= '0;
                        if (eff_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ON;
                            busy  <= 1'b1;
                            led   <= decode(sel_seq[0]);
                        end
                    end
                end
                ON: begin
                    if (bus.i_abort) begin
                        state <= IDLE;
                        led   <= '0;
                        busy  <= 1'b0;
                        timer <= '0;
                    end else if (timer == CNT_W'(ON_CYCLES - 1)) begin
                        state <= OFF;
                        led   <= '0;
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                OFF: begin
                    if (bus.i_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        timer <= '0;
                    end else if (timer == CNT_W'(OFF_CYCLES - 1)) begin
                        timer <= '0;
                        if (step == len_snap - LEN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ON;
                            step  <= step_nxt;
                            led   <= decode(seq_snap[idx_nxt]);
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    led   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    led   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_led  = led;
    assign bus.o_busy = busy;
    assign bus.o_done = done;
    assign bus.o_step = step;

endmodule
